// File: rtl/threadbrain_pkg.sv
// Shared constants for the multicore array: datapath width, opcodes and
// reset values, plus small helpers used by the print path.
package threadbrain_pkg;

   localparam int WORD_W = 16;

   typedef logic [WORD_W-1:0] word_t;

   localparam logic [3:0] OP_PLUS  = 4'd1;
   localparam logic [3:0] OP_MINUS = 4'd2;
   localparam logic [3:0] OP_INC   = 4'd3;
   localparam logic [3:0] OP_DEC   = 4'd4;
   localparam logic [3:0] OP_BRZ   = 4'd5;
   localparam logic [3:0] OP_BR    = 4'd6;
   localparam logic [3:0] OP_SYNC  = 4'd8;
   localparam logic [3:0] OP_PRINT = 4'd9;

   localparam word_t RESET_DPTR = 16'd128;

   // Core-id width; a single-core array still carries a 1-bit id.
   function automatic int id_width(input int ncores);
      return (ncores <= 1) ? 1 : $clog2(ncores);
   endfunction

endpackage

// File: rtl/print_unit_sync_fifo.sv
// Register-based first-word-fall-through FIFO. The head entry sits in its own
// register so the output only changes on a pop or on a push into an empty FIFO.
module sync_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
   localparam logic [AW:0] ONE_LVL  = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_next;
   logic [AW:0]      count;
   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] head_nxt;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop & (count != '0);
   assign do_push = push & ((count != FULL_LVL) | do_pop);
   assign rd_next = rd_ptr + 1'b1;

   // Storage needs no reset; occupancy and the head register define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // A pop at full with a simultaneous push overwrites the slot being popped,
   // which is safe because the new head is taken from the following slot.
   always_comb begin
      head_nxt = head_q;
      if (do_pop) begin
         if (count > ONE_LVL) begin
            head_nxt = mem[rd_next];
         end else if (do_push) begin
            head_nxt = din;
         end
      end else if (do_push && (count == '0)) begin
         head_nxt = din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head_q <= '0;
      end else begin
         head_q <= head_nxt;
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_next;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign dout  = head_q;
   assign valid = (count != '0);
   assign level = count;

endmodule

// File: rtl/print_unit.sv
// Consumer end of the per-core print path: round-robin pick of one printing
// core per cycle, queue {core id, value}, stall every core not granted.
module print_unit
   import threadbrain_pkg::*;
#(
   parameter int NCORES = 4,
   parameter int DEPTH  = 8,
   parameter int IDW    = id_width(NCORES)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NCORES*16-1:0]     print_vals,
   input  logic [NCORES-1:0]        print_valids,
   output logic [NCORES-1:0]        core_stall,
   output logic [15:0]              out_data,
   output logic [IDW-1:0]           out_core,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int EW = IDW + WORD_W;
   localparam logic [$clog2(DEPTH):0] FULL_LVL = DEPTH[$clog2(DEPTH):0];
   localparam logic [IDW-1:0] LAST_ID = IDW'(NCORES - 1);

   logic [IDW-1:0]    rr_ptr;
   logic [IDW-1:0]    grant_id;
   logic [IDW-1:0]    cand;
   logic              any_grant;
   logic [NCORES-1:0] grant;
   logic              pop;
   logic              can_push;
   logic [EW-1:0]     push_data;
   logic [EW-1:0]     head;

   assign pop      = out_valid & out_ready;
   assign can_push = (level != FULL_LVL) | pop;

   // Scan from rr_ptr with wrap; the first requester wins if there is room.
   always_comb begin
      grant     = '0;
      grant_id  = '0;
      any_grant = 1'b0;
      cand      = '0;
      for (int k = 0; k < NCORES; k++) begin
         cand = IDW'((int'(rr_ptr) + k) % NCORES);
         if (!any_grant && print_valids[cand]) begin
            any_grant = 1'b1;
            grant_id  = cand;
         end
      end
      if (rst || !can_push) begin
         any_grant = 1'b0;
      end
      if (any_grant) begin
         grant[grant_id] = 1'b1;
      end
   end

   assign core_stall = print_valids & ~grant;
   assign push_data  = {grant_id, print_vals[int'(grant_id)*WORD_W +: WORD_W]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (any_grant) begin
         rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      end
   end

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (any_grant),
      .din   (push_data),
      .pop   (pop),
      .dout  (head),
      .valid (out_valid),
      .level (level)
   );

   assign out_core = head[EW-1 -: IDW];
   assign out_data = head[WORD_W-1:0];

endmodule

// File: tb/tb_print_unit.sv
// Directed bench for print_unit: expected {core, value} pairs are queued as
// prints are driven and compared when the output port hands them over.
module tb_print_unit;

   localparam int NC = 4;
   localparam int DP = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [63:0]   print_vals;
   logic [3:0]    print_valids;
   logic [3:0]    core_stall;
   logic [15:0]   out_data;
   logic [1:0]    out_core;
   logic          out_valid;
   logic          out_ready;
   logic [3:0]    level;

   int            checks = 0;
   int            failures = 0;
   logic [17:0]   exp_q[$];
   logic [17:0]   exp_e;
   int            core_cnt[4];

   print_unit #(.NCORES(NC), .DEPTH(DP)) dut (
      .clk          (clk),
      .rst          (rst),
      .print_vals   (print_vals),
      .print_valids (print_valids),
      .core_stall   (core_stall),
      .out_data     (out_data),
      .out_core     (out_core),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .level        (level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_val(input int c, input logic [15:0] v);
      print_vals[c*16 +: 16] = v;
   endtask

   task automatic drain();
      out_ready    = 1'b1;
      print_valids = '0;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
      chk("drain_empty", exp_q.size(), 0);
      @(negedge clk);
      chk("drain_level", level, 0);
      chk("drain_valid", out_valid, 0);
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_q.delete();
   endtask

   // Output monitor: each accepted head must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL unexpected_out observed=%0h expected=none", {out_core, out_data});
         end else begin
            exp_e = exp_q.pop_front();
            chk("out_data", out_data, exp_e[15:0]);
            chk("out_core", out_core, exp_e[17:16]);
            core_cnt[out_core]++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int lvl;
      int nxt;
      int cyc;
      int g;
      int gcount[4];
      logic exp_grant;
      logic rdy_pop;

      rst          = 1'b1;
      print_vals   = '0;
      print_valids = 4'b1010;
      out_ready    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_data", out_data, 0);
      chk("rst_core", out_core, 0);
      chk("rst_stall", core_stall, 4'b1010);
      step();
      print_valids = '0;
      rst = 1'b0;

      // Single print from core 2
      out_ready = 1'b1;
      set_val(2, 16'h0041);
      print_valids = 4'b0100;
      exp_q.push_back({2'd2, 16'h0041});
      @(negedge clk);
      chk("single_stall", core_stall, 4'b0000);
      step();
      print_valids = '0;
      @(negedge clk);
      chk("single_valid", out_valid, 1);
      step();
      drain();

      // Contention: cores 0, 1, 3 from rr_ptr = 0
      do_reset();
      out_ready = 1'b1;
      set_val(0, 16'h0A00);
      set_val(1, 16'h0A01);
      set_val(3, 16'h0A03);
      print_valids = 4'b1011;
      exp_q.push_back({2'd0, 16'h0A00});
      exp_q.push_back({2'd1, 16'h0A01});
      exp_q.push_back({2'd3, 16'h0A03});
      @(negedge clk);
      chk("cont_stall0", core_stall, 4'b1010);
      step();
      print_valids = 4'b1010;
      @(negedge clk);
      chk("cont_stall1", core_stall, 4'b1000);
      step();
      print_valids = 4'b1000;
      @(negedge clk);
      chk("cont_stall2", core_stall, 4'b0000);
      step();
      print_valids = '0;
      @(negedge clk);
      chk("cont_rr_ptr", dut.rr_ptr, 0);
      step();
      drain();

      // Fill to DEPTH with the output blocked
      out_ready = 1'b0;
      for (int i = 0; i < DP; i++) begin
         set_val(0, 16'h0100 + 16'(i));
         print_valids = 4'b0001;
         exp_q.push_back({2'd0, 16'h0100 + 16'(i)});
         @(negedge clk);
         chk("fill_stall", core_stall, 4'b0000);
         step();
      end
      print_valids = '0;
      @(negedge clk);
      chk("fill_level", level, 8);
      chk("fill_head", out_data, 16'h0100);
      step();
      set_val(1, 16'h0999);
      print_valids = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("full_stall", core_stall, 4'b0010);
         chk("full_level", level, 8);
         step();
      end
      out_ready = 1'b1;
      exp_q.push_back({2'd1, 16'h0999});
      @(negedge clk);
      chk("full_release_stall", core_stall, 4'b0000);
      chk("full_release_level", level, 8);
      step();
      print_valids = '0;
      @(negedge clk);
      chk("full_swap_level", level, 8);
      step();
      drain();

      // Wrap: 20 values from core 3 with out_ready toggling
      lvl = 0;
      nxt = 1;
      cyc = 0;
      while (nxt <= 20 && cyc < 200) begin
         out_ready = (cyc % 2 == 0);
         set_val(3, 16'(nxt));
         print_valids = 4'b1000;
         rdy_pop   = (lvl > 0) && out_ready;
         exp_grant = (lvl < DP) || rdy_pop;
         @(negedge clk);
         chk("wrap_level", level, lvl);
         chk("wrap_stall", core_stall, exp_grant ? 4'b0000 : 4'b1000);
         if (exp_grant) begin
            exp_q.push_back({2'd3, 16'(nxt)});
            nxt++;
         end
         lvl = lvl + (exp_grant ? 1 : 0) - (rdy_pop ? 1 : 0);
         step();
         cyc++;
      end
      chk("wrap_budget", nxt, 21);
      drain();

      // Fairness: all cores request continuously for 16 grants
      chk("fair_rr_start", dut.rr_ptr, 0);
      for (int c = 0; c < 4; c++) begin
         core_cnt[c] = 0;
         gcount[c]   = 0;
      end
      out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         g = k % 4;
         for (int c = 0; c < 4; c++) set_val(c, 16'(c * 16'h1000 + gcount[c]));
         print_valids = 4'b1111;
         exp_q.push_back({2'(g), 16'(g * 16'h1000 + gcount[g])});
         @(negedge clk);
         chk("fair_stall", core_stall, 4'b1111 & ~(4'b0001 << g));
         gcount[g]++;
         step();
      end
      drain();
      for (int c = 0; c < 4; c++) chk("fair_count", core_cnt[c], 4);

      // Reset in the middle of operation
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_val(0, 16'h0500 + 16'(i));
         print_valids = 4'b0001;
         exp_q.push_back({2'd0, 16'h0500 + 16'(i)});
         step();
      end
      print_valids = '0;
      @(negedge clk);
      chk("pre_rst_level", level, 5);
      step();
      set_val(1, 16'h0111);
      set_val(2, 16'h0222);
      print_valids = 4'b0110;
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_level", level, 0);
      chk("async_rst_stall", core_stall, 4'b0110);
      exp_q.delete();
      step();
      rst = 1'b0;
      exp_q.push_back({2'd1, 16'h0111});
      @(negedge clk);
      chk("post_rst_stall0", core_stall, 4'b0100);
      step();
      print_valids = 4'b0100;
      exp_q.push_back({2'd2, 16'h0222});
      @(negedge clk);
      chk("post_rst_stall1", core_stall, 4'b0000);
      step();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
